// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: buffers the first half of each
// 2*DELAY block, emits modular sums, then drains the modular differences.
module sdf_r2_stage #(
  parameter int               DELAY   = 4,
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MODULUS = 32'd7681
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_diff
);
  localparam int               CW        = $clog2(2*DELAY);
  localparam logic [CW-1:0]    HALF_LAST = CW'(DELAY-1);
  localparam logic [CW-1:0]    BLK_LAST  = CW'(2*DELAY-1);
  localparam logic [WIDTH:0]   M_EXT     = {1'b0, MODULUS};

  typedef enum logic [1:0] {FILL, BFLY, CHK, DRAIN} state_t;
  typedef struct packed {
    logic             vld;
    logic             diff;
    logic [WIDTH-1:0] data;
  } rsp_t;

  state_t                      state, nxt_state;
  logic [CW-1:0]               cnt, nxt_cnt;
  logic                        pend, nxt_pend;
  logic [DELAY-1:0][WIDTH-1:0] fb;
  logic [WIDTH-1:0]            fb_out, fb_in;
  logic                        shift, rdy_st, acc;
  logic [WIDTH:0]              sum_ext, dif_ext;
  logic [WIDTH-1:0]            sum_res, dif_res;
  rsp_t                        rsp_d, rsp_q;

  assign fb_out = fb[DELAY-1];

  // Operands are both < MODULUS, so one conditional correction suffices.
  assign sum_ext = {1'b0, fb_out} + {1'b0, in_data};
  assign dif_ext = {1'b0, fb_out} - {1'b0, in_data};
  assign sum_res = (sum_ext >= M_EXT) ? WIDTH'(sum_ext - M_EXT) : WIDTH'(sum_ext);
  assign dif_res = dif_ext[WIDTH]     ? WIDTH'(dif_ext + M_EXT) : WIDTH'(dif_ext);

  assign rdy_st   = (state != DRAIN);
  assign in_ready = reset & rdy_st;
  assign acc      = in_valid & rdy_st;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pend  = pend;
    shift     = 1'b0;
    fb_in     = '0;
    rsp_d     = rsp_q;
    rsp_d.vld = 1'b0;
    case (state)
      FILL, CHK: begin
        // CHK resolves in the cycle after a block ends: a waiting sample keeps
        // the stream going, an idle input flushes the pending diffs.
        if (state == CHK && !in_valid) begin
          nxt_state = DRAIN;
        end else if (acc) begin
          fb_in   = in_data;
          shift   = 1'b1;
          nxt_cnt = cnt + 1'b1;
          if (pend) begin
            rsp_d.vld  = 1'b1;
            rsp_d.diff = 1'b1;
            rsp_d.data = fb_out;
          end
          if (cnt == HALF_LAST) begin
            nxt_state = BFLY;
            nxt_pend  = 1'b0;
          end else begin
            nxt_state = FILL;
          end
        end
      end
      BFLY: begin
        if (acc) begin
          fb_in      = dif_res;
          shift      = 1'b1;
          rsp_d.vld  = 1'b1;
          rsp_d.diff = 1'b0;
          rsp_d.data = sum_res;
          if (cnt == BLK_LAST) begin
            nxt_cnt   = '0;
            nxt_pend  = 1'b1;
            nxt_state = CHK;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        shift      = 1'b1;
        rsp_d.vld  = 1'b1;
        rsp_d.diff = 1'b1;
        rsp_d.data = fb_out;
        if (cnt == HALF_LAST) begin
          nxt_cnt   = '0;
          nxt_pend  = 1'b0;
          nxt_state = FILL;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: nxt_state = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      cnt   <= '0;
      pend  <= 1'b0;
      rsp_q <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      pend  <= nxt_pend;
      rsp_q <= rsp_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb <= '0;
    end else if (shift) begin
      fb[0] <= fb_in;
      for (int i = 1; i < DELAY; i++) fb[i] <= fb[i-1];
    end
  end

  assign out_valid = rsp_q.vld;
  assign out_diff  = rsp_q.diff;
  assign out_data  = rsp_q.data;
endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage: directed and random streams against a block-level
// butterfly model (sums then diffs per block), DELAY=4 and DELAY=1 instances.
module tb_sdf_r2_stage;
  localparam int M = 17;

  logic        clk, reset;
  logic        in_valid4, in_ready4, out_valid4, out_diff4;
  logic [31:0] in_data4, out_data4;
  logic        in_valid1, in_ready1, out_valid1, out_diff1;
  logic [31:0] in_data1, out_data1;

  int checks = 0, errors = 0, stalls4 = 0, viol4 = 0;
  logic prev_ok4 = 1'b0;
  logic [32:0] q4[$], q1[$], got[$], exp_q[$];
  int samp_q[$];

  sdf_r2_stage #(.DELAY(4), .WIDTH(32), .MODULUS(32'd17)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_data(out_data4), .out_diff(out_diff4));

  sdf_r2_stage #(.DELAY(1), .WIDTH(32), .MODULUS(32'd17)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_data(out_data1), .out_diff(out_diff1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output collection, plus: an output may only follow an accept or a drain cycle.
  always @(negedge clk) begin
    if (out_valid4) q4.push_back({out_diff4, out_data4});
    if (out_valid1) q1.push_back({out_diff1, out_data1});
    if (out_valid4 && !prev_ok4) viol4++;
    prev_ok4 = (in_valid4 && in_ready4) || (!in_ready4 && reset);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Per block of 2d samples: d sums, then d diffs, all mod M.
  task automatic model(input int d);
    int nb;
    nb = samp_q.size() / (2*d);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < d; i++)
        exp_q.push_back({1'b0, 32'((samp_q[b*2*d+i] + samp_q[b*2*d+i+d]) % M)});
      for (int i = 0; i < d; i++)
        exp_q.push_back({1'b1, 32'((samp_q[b*2*d+i] - samp_q[b*2*d+i+d] + M) % M)});
    end
    samp_q.delete();
  endtask

  task automatic chk_q(input string tag);
    int n;
    checks++;
    assert (got.size() == exp_q.size()) else begin
      errors++;
      $error("FAIL %s_len observed=%0d expected=%0d", tag, got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (got[i] === exp_q[i]) else begin
        errors++;
        $error("FAIL %s[%0d] observed diff=%0b data=%0d expected diff=%0b data=%0d",
               tag, i, got[i][32], got[i][31:0], exp_q[i][32], exp_q[i][31:0]);
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic send4(input int d);
    int w;
    w = 0;
    in_valid4 = 1'b1;
    in_data4  = 32'(d);
    samp_q.push_back(d);
    @(negedge clk);
    while (!in_ready4 && w < 100) begin
      stalls4++; w++;
      @(negedge clk);
    end
    if (w >= 100) begin
      checks++; errors++;
      $error("FAIL send4_timeout observed=stalled expected=accept");
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic send1(input int d);
    int w;
    w = 0;
    in_valid1 = 1'b1;
    in_data1  = 32'(d);
    @(negedge clk);
    while (!in_ready1 && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) begin
      checks++; errors++;
      $error("FAIL send1_timeout observed=stalled expected=accept");
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int nrdy;
    int wr[8];
    reset = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0;
    in_valid1 = 1'b0; in_data1 = '0;

    // Reset state
    #2;
    chk("rst_valid", 32'(out_valid4), 32'd0);
    chk("rst_data",  out_data4, 32'd0);
    chk("rst_diff",  32'(out_diff4), 32'd0);
    chk("rst_ready", 32'(in_ready4), 32'd0);
    @(negedge clk); reset = 1'b1; #1;
    chk("rel_ready", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;

    // Single block 0..7, latency and drain length
    for (int i = 0; i < 4; i++) send4(i);
    chk("pre_first_valid", 32'(out_valid4), 32'd0);
    send4(4);
    chk("first_valid", 32'(out_valid4), 32'd1);
    chk("first_data",  out_data4, 32'd4);
    for (int i = 5; i < 8; i++) send4(i);
    nrdy = 0;
    repeat (14) begin
      @(negedge clk);
      if (!in_ready4) nrdy++;
    end
    @(posedge clk); #1;
    chk("drain_cycles", 32'(nrdy), 32'd4);
    model(4); got = q4; q4.delete();
    chk_q("blk1");

    // Two blocks back-to-back: no drain between them
    stalls4 = 0;
    for (int i = 0; i < 16; i++) send4(i);
    chk("b2b_stalls", 32'(stalls4), 32'd0);
    idle(12);
    model(4); got = q4; q4.delete();
    chk_q("blk2");

    // Wrap boundaries
    wr = '{16, 3, 10, 0, 16, 10, 3, 0};
    for (int i = 0; i < 8; i++) send4(wr[i]);
    idle(12);
    samp_q.delete();
    exp_q = '{{1'b0, 32'd15}, {1'b0, 32'd13}, {1'b0, 32'd13}, {1'b0, 32'd0},
              {1'b1, 32'd0},  {1'b1, 32'd10}, {1'b1, 32'd7},  {1'b1, 32'd0}};
    got = q4; q4.delete();
    chk_q("wrap");

    // Random gaps over 10 blocks
    viol4 = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
      send4(int'($urandom_range(0, M-1)));
    end
    idle(14);
    chk("idle_outputs", 32'(viol4), 32'd0);
    model(4); got = q4; q4.delete();
    chk_q("rand");

    // Asynchronous reset mid-BFLY
    for (int i = 0; i < 5; i++) send4(i);
    chk("mid_valid", 32'(out_valid4), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid4), 32'd0);
    chk("async_data",  out_data4, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    q4.delete(); samp_q.delete();
    for (int i = 0; i < 8; i++) send4(i);
    idle(12);
    model(4); got = q4; q4.delete();
    chk_q("post_rst");

    // DELAY=1 instance
    q1.delete();
    send1(5); send1(9); send1(16); send1(1);
    idle(6);
    exp_q = '{{1'b0, 32'd14}, {1'b1, 32'd13}, {1'b0, 32'd0}, {1'b1, 32'd15}};
    got = q1; q1.delete();
    chk_q("d1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdf_r2_stage.md
Name: sdf_r2_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the pipelined NTT datapath.
- Consumes one coefficient per cycle and holds the first half of each 2*DELAY block in an internal enable-gated feedback shift line.
- Emits the modular sums, then the modular differences, as a serial stream.
- Sits directly upstream of the twiddle multiplier and the next fixed delay line; the diff-half flag drives twiddle selection.

Parameters:
- DELAY, 4, half-span of the butterfly; feedback line depth; block length = 2*DELAY (DELAY >= 1).
- WIDTH, 32, coefficient width.
- MODULUS, 32'd7681, NTT prime; must satisfy 2 <= MODULUS < 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  stage accepts a sample this cycle.
- in_data  in  WIDTH  coefficient; must be < MODULUS.
- out_valid  out  1  out_data valid this cycle.
- out_data  out  WIDTH  result, always < MODULUS.
- out_diff  out  1  1 = out_data is a difference (second half), 0 = sum.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0, except in_ready=1 once reset is released.
  - Feedback line cleared; counter = 0; state = FILL.
- Accept: acc = in_valid & in_ready. No output backpressure.
- Counter cnt, 0..2*DELAY-1:
  - Increments on acc; wraps to 0 after 2*DELAY-1.
  - Phase A = cnt < DELAY; phase B = cnt >= DELAY.
- Feedback line: DELAY entries, shifted only when shift_en=1.
  - fb_out = oldest entry; fb_in is written at the head on each shift.
- States:
  - FILL: phase A.
    - On acc: fb_in = in_data; shift.
    - If pending=1, the diff leaving the line is emitted (out_valid=1, out_diff=1).
    - pending is set at the end of BFLY and cleared when DELAY diffs have left the line.
    - Leaves to BFLY when the acc at cnt=DELAY-1 occurs.
  - BFLY: phase B.
    - On acc, with a = fb_out and b = in_data:
      - out_data = (a+b) mod M; out_diff = 0.
      - fb_in = (a-b) mod M; shift.
    - On the acc at cnt=2*DELAY-1: pending=1, go to CHK.
  - CHK (transient, evaluated in the same cycle as the next input):
    - in_valid=1: behaves as FILL (stream continues, diffs drain alongside new samples).
    - in_valid=0: go to DRAIN.
  - DRAIN:
    - in_ready=0.
    - Shift every cycle (fb_in = 0); emit one diff per cycle, DELAY cycles total.
    - Then return to FILL with cnt = 0 and pending = 0.
- Arithmetic:
  - Sum in WIDTH+1 bits; subtract M if >= M.
  - Diff: a-b in WIDTH+1 bits; add M if negative.
  - Result truncated to WIDTH.
- Output timing:
  - out_* are registered; valid 1 cycle after the accept (or drain shift) that produced them.
  - out_valid=0 otherwise; out_data holds its last value when out_valid=0.
- Input gaps: in_valid=0 in FILL/BFLY → nothing shifts, counter holds; the stream resumes seamlessly.
- Reset mid-block: all partial data is discarded; the next accepted sample is index 0.
- DELAY=1: FILL and BFLY alternate every sample; DRAIN lasts 1 cycle.

Test Plan:
- DELAY=4, M=17, samples 0..7 back-to-back, then in_valid=0 → outputs 4,6,8,10 (out_diff=0), then DRAIN 13,13,13,13 (out_diff=1); in_ready=0 for exactly 4 cycles. First output appears 1 cycle after sample 4 is accepted.
- Two blocks back-to-back (0..7 then 8..15) → diffs of block 1 (13×4) are interleaved during block 2's FILL. Then 20→3, 22→5, 24→7, 26→9 (sums mod 17), then drain 13×4. No DRAIN occurs between the blocks.
- Wrap boundaries, M=17: pair (16,16) → sum 15, diff 0; pair (3,10) → sum 13, diff 10; pair (10,3) → diff 7; pair (0,0) → 0,0.
- Random in_valid gaps (30% idle) over 10 blocks → output sequence identical to the gap-free reference model; no out_valid while idle except during DRAIN.
- Assert reset=0 asynchronously mid-BFLY (cnt=5) → outputs go to 0 immediately without a clock edge. After release, a fresh block 0..7 reproduces 4,6,8,10,13,13,13,13.
- DELAY=1, M=17, stream 5,9,16,1 → 14,13(diff), 0,15(diff) in order.
